// File: rtl/baud_frame_gen.sv
// Baud-rate frame generator: fractional-N bit timer that walks through a
// frame of FRAME_BITS bits, emitting a mid-bit sample strobe, a per-bit end
// strobe and an end-of-frame strobe. Divisors are captured only while idle.
module baud_frame_gen #(
  parameter int CNT_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int DIV_RESET  = 434,
  parameter int FRAC_RESET = 0,
  parameter int FRAME_BITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bps_start,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              bps_clk,
  output logic              bit_end,
  output logic              frame_done,
  output logic              busy,
  output logic [3:0]        bit_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0]       LAST_IDX = 4'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(3);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [3:0]          bit_idx_q, bit_idx_d;

  logic                run;
  logic [FRAC_W:0]     acc_sum;
  logic                carry;
  logic [CNT_W:0]      last_cnt;
  logic                last_bit;

  // The fractional carry stretches the current bit by one cycle; the
  // accumulator itself only advances when the bit completes.
  assign run      = (state_q == RUN);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};
  assign carry    = acc_sum[FRAC_W];
  assign last_cnt = {1'b0, div_q} + {{CNT_W{1'b0}}, carry} - {{CNT_W{1'b0}}, 1'b1};
  assign last_bit = (bit_idx_q == LAST_IDX);

  // Strobes are decoded straight from registered state, so they all drop to
  // zero the instant reset forces IDLE.
  assign bps_clk    = run && (cnt_q == (div_q >> 1));
  assign bit_end    = run && ({1'b0, cnt_q} == last_cnt);
  assign frame_done = bit_end && last_bit;
  assign busy       = run;
  assign bit_idx    = bit_idx_q;

  // Divisor capture: only honoured in IDLE, with a floor of 3 so the
  // mid-bit strobe and the bit-end strobe can never land on the same cycle.
  always_comb begin
    div_d  = div_q;
    frac_d = frac_q;
    if (!run && div_load) begin
      div_d  = (div_int < DIV_MIN) ? DIV_MIN : div_int;
      frac_d = div_frac;
    end
  end

  // Next-state logic for the IDLE/RUN sequencer and its bit/frame counters.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        acc_d     = '0;
        bit_idx_d = '0;
        if (bps_start) state_d = RUN;
      end
      RUN: begin
        if (!bps_start) begin
          // Dropping the enable abandons the frame without a frame_done.
          state_d   = IDLE;
          cnt_d     = '0;
          acc_d     = '0;
          bit_idx_d = '0;
        end else if (bit_end) begin
          // Wrap to bit 0 on the last bit so frames run back to back.
          cnt_d     = '0;
          acc_d     = acc_sum[FRAC_W-1:0];
          bit_idx_d = last_bit ? 4'd0 : bit_idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      bit_idx_q <= '0;
      div_q     <= CNT_W'(DIV_RESET);
      frac_q    <= FRAC_W'(FRAC_RESET);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
      frac_q    <= frac_d;
    end
  end

endmodule

// File: tb/tb_baud_frame_gen.sv
// Directed bench for baud_frame_gen: expected strobe events are queued when a
// frame is launched and matched against the DUT as the strobes appear.
module tb_baud_frame_gen;

  localparam int CNT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int FB     = 10;

  logic              clk;
  logic              rst;
  logic              bps_start;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              bps_clk;
  logic              bit_end;
  logic              frame_done;
  logic              busy;
  logic [3:0]        bit_idx;

  baud_frame_gen #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .DIV_RESET(434), .FRAC_RESET(0), .FRAME_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .bps_start(bps_start), .div_int(div_int),
    .div_frac(div_frac), .div_load(div_load), .bps_clk(bps_clk),
    .bit_end(bit_end), .frame_done(frame_done), .busy(busy), .bit_idx(bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = bps_clk, 1 = bit_end, 2 = frame_done
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  idx;
    logic [31:0] t;
  } ev_t;

  ev_t exp_q[$];
  int  passed = 0;
  int  failed = 0;
  int  total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input int t);
    ev_t e;
    e.kind = 2'(kind);
    e.idx  = 4'(idx);
    e.t    = 32'(t);
    exp_q.push_back(e);
  endtask

  // Expected timeline of one frame starting with cnt=0 at cycle base.
  // Bits below cut are planned completely; bit cut (if inside the frame)
  // only gets its mid-bit strobe. s_out is the start cycle of bit cut.
  task automatic plan(input int base, input int d, input int f, input int cut,
                      input int acc_in, output int acc_out, output int s_out);
    int s, a, c, p;
    s = base;
    a = acc_in;
    for (int k = 0; k < FB; k++) begin
      c = ((a + f) >= (1 << FRAC_W)) ? 1 : 0;
      p = d + c;
      if (k < cut) begin
        push(0, k, s + d / 2);
        push(1, k, s + p - 1);
        if (k == FB - 1) push(2, k, s + p - 1);
        a = (a + f) % (1 << FRAC_W);
        s = s + p;
      end else if (k == cut) begin
        push(0, k, s + d / 2);
      end
    end
    acc_out = a;
    s_out   = s;
  endtask

  task automatic check_ev(input logic [1:0] k, input string tag);
    ev_t obs, ex;
    obs.kind = k;
    obs.idx  = bit_idx;
    obs.t    = 32'(cyc);
    if (exp_q.size() == 0) ex = '1;
    else ex = exp_q.pop_front();
    check(tag, 64'(obs), 64'(ex));
  endtask

  // Every strobe the DUT raises must match the next planned event.
  always @(negedge clk) begin
    if (bps_clk) begin
      check_ev(2'd0, "ev_bps_clk");
      check("no_overlap", 64'(bit_end), 64'd0);
    end
    if (bit_end) begin
      check_ev(2'd1, "ev_bit_end");
      check("busy_in_frame", 64'(busy), 64'd1);
    end
    if (frame_done) check_ev(2'd2, "ev_frame_done");
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_tmp, a_tmp2, s_end, s_end2, c;
    rst = 1'b0; bps_start = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bps_clk", 64'(bps_clk), 64'd0);
    check("rst_bit_end", 64'(bit_end), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_bit_idx", 64'(bit_idx), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start", 64'(busy), 64'd0);

    // Default divisor, one full frame
    c = cyc;
    bps_start = 1'b1;
    plan(c + 1, 434, 0, FB, 0, a_tmp, s_end);
    wait_cyc(c + 1 + 1000);
    check("dflt_busy_mid", 64'(busy), 64'd1);
    check("dflt_idx_mid", 64'(bit_idx), 64'd2);
    wait_cyc(s_end - 1);
    bps_start = 1'b0;
    @(negedge clk);
    check("dflt_end_busy", 64'(busy), 64'd0);
    check("dflt_end_idx", 64'(bit_idx), 64'd0);
    check("dflt_drained", 64'(exp_q.size()), 64'd0);

    // Fractional divisor 10 + 8/16, two frames back to back, load during RUN ignored
    div_int = 16'd10; div_frac = 4'd8; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    c = cyc;
    bps_start = 1'b1;
    plan(c + 1, 10, 8, FB, 0, a_tmp, s_end);
    plan(s_end, 10, 8, FB, a_tmp, a_tmp2, s_end2);
    wait_cyc(c + 30);
    div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    wait_cyc(s_end);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_idx", 64'(bit_idx), 64'd0);
    wait_cyc(s_end2 - 1);
    bps_start = 1'b0;
    @(negedge clk);
    check("frac_end_busy", 64'(busy), 64'd0);
    check("frac_drained", 64'(exp_q.size()), 64'd0);

    // div_int=1 clamps to 3; load and start on the same edge
    div_int = 16'd1; div_frac = 4'd0; div_load = 1'b1; bps_start = 1'b1;
    c = cyc;
    plan(c + 1, 3, 0, FB, 0, a_tmp, s_end);
    @(negedge clk);
    div_load = 1'b0;
    wait_cyc(s_end - 1);
    bps_start = 1'b0;
    @(negedge clk);
    check("min_drained", 64'(exp_q.size()), 64'd0);

    // Abort at bit 4 with 10 + 6/16, then restart from a clean bit 0
    div_int = 16'd10; div_frac = 4'd6; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    c = cyc;
    bps_start = 1'b1;
    plan(c + 1, 10, 6, 4, 0, a_tmp, s_end);
    wait_cyc(s_end + 6);
    check("abort_idx_before", 64'(bit_idx), 64'd4);
    bps_start = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_idx", 64'(bit_idx), 64'd0);
    check("abort_no_done", 64'(frame_done), 64'd0);
    check("abort_drained", 64'(exp_q.size()), 64'd0);
    c = cyc;
    bps_start = 1'b1;
    plan(c + 1, 10, 6, 2, 0, a_tmp, s_end);
    @(negedge clk);
    check("restart_idx", 64'(bit_idx), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);

    // Asynchronous reset in the middle of bit 2
    wait_cyc(s_end + 7);
    check("pre_rst_idx", 64'(bit_idx), 64'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_bps_clk", 64'(bps_clk), 64'd0);
    check("mid_rst_bit_end", 64'(bit_end), 64'd0);
    check("mid_rst_frame_done", 64'(frame_done), 64'd0);
    check("mid_rst_idx", 64'(bit_idx), 64'd0);
    bps_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    check("rst_drained", 64'(exp_q.size()), 64'd0);

    // Divisor back to its reset value of 434
    c = cyc;
    bps_start = 1'b1;
    plan(c + 1, 434, 0, 1, 0, a_tmp, s_end);
    wait_cyc(s_end + 220);
    bps_start = 1'b0;
    @(negedge clk);
    check("reset_div_busy", 64'(busy), 64'd0);
    check("reset_div_drained", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/baud_frame_gen.md
BAUD_FRAME_GEN -- requirements
Module: baud_frame_gen

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of the integer divisor and the bit counter.
REQ-002 SHALL provide parameter FRAC_W, default 4, width of the fractional divisor and its accumulator.
REQ-003 SHALL provide parameter DIV_RESET, default 434, integer divisor loaded at reset.
REQ-004 SHALL provide parameter FRAC_RESET, default 0, fractional divisor loaded at reset.
REQ-005 SHALL provide parameter FRAME_BITS, default 10, bits per frame; legal range 1..15.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 bps_start  input  1  level enable; high starts a frame and sustains it.
REQ-009 div_int  input  CNT_W  integer cycles per bit.
REQ-010 div_frac  input  FRAC_W  fractional cycles per bit, in units of 1/2^FRAC_W.
REQ-011 div_load  input  1  one-cycle strobe capturing div_int and div_frac.
REQ-012 bps_clk  output  1  one-cycle pulse at the mid-bit sample point.
REQ-013 bit_end  output  1  one-cycle pulse on the last cycle of each bit.
REQ-014 frame_done  output  1  one-cycle pulse on the last cycle of the frame.
REQ-015 busy  output  1  high while in state RUN.
REQ-016 bit_idx  output  4  index of the current bit, 0..FRAME_BITS-1.

Function
REQ-017 SHALL hold registers div_q and frac_q; div_load captures them only in IDLE; div_load in RUN is ignored.
REQ-018 SHALL clamp div_int values below 3 to 3 on capture.
REQ-019 SHALL implement a two-state FSM: IDLE and RUN.
REQ-020 In IDLE: cnt, acc and bit_idx SHALL be 0.
REQ-021 IDLE->RUN SHALL occur on the edge sampling bps_start=1; cnt=0 after that edge.
REQ-022 If div_load and bps_start are both high in IDLE on the same edge, the newly captured divisor SHALL govern the frame.
REQ-023 The period of each bit SHALL be P = div_q + c cycles, where c is the carry-out of acc + frac_q (FRAC_W-bit add).
REQ-024 cnt SHALL increment by 1 per cycle in RUN.
REQ-025 At cnt == P-1: cnt SHALL go to 0, acc SHALL take (acc + frac_q) mod 2^FRAC_W, and bit_idx SHALL increment.
REQ-026 bps_clk SHALL be high iff RUN and cnt == div_q>>1; bit_end SHALL be high iff RUN and cnt == P-1; both are decoded from registered state with no extra latency.
REQ-027 frame_done SHALL be high iff bit_end and bit_idx == FRAME_BITS-1.
REQ-028 At frame_done, if bps_start=1 the FSM SHALL stay in RUN with bit_idx=0 (back-to-back, no gap); otherwise it SHALL go to IDLE.
REQ-029 bps_start=0 in RUN SHALL abort on the next edge: go to IDLE and clear cnt, acc and bit_idx; frame_done is not asserted.
REQ-030 bps_clk and bit_end SHALL never coincide; the minimum div_q of 3 guarantees this.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, cnt=0, acc=0, bit_idx=0, div_q=DIV_RESET, frac_q=FRAC_RESET, and all outputs to 0, including mid-frame.
REQ-032 After rst deasserts, the first frame SHALL require bps_start sampled high.

Verification
REQ-033 Defaults, bps_start held high from edge E0 -> bps_clk after E0+217, bit_end after E0+433, frame_done after E0+4339, bit_idx 0..9, busy continuously high.
REQ-034 div_load with div_int=10, div_frac=8, FRAC_W=4, then bps_start -> bit periods 10,11,10,11,...; bps_clk at cnt=5 in every bit.
REQ-035 div_int=1 loaded -> div_q=3; bps_clk at cnt 1, bit_end at cnt 2; the two never coincide.
REQ-036 bps_start dropped at bit_idx=4 -> IDLE next edge, busy=0, no frame_done; restart begins at bit_idx=0, cnt=0.
REQ-037 div_load pulsed in RUN -> divisor unchanged for the current and all following frames until a load occurs in IDLE.
REQ-038 rst asserted mid-bit with div_q=10 -> all outputs 0 immediately; div_q returns to 434.
